// File: rtl/mult32x32_fsm_if.sv
// rtl/mult32x32_fsm_if.sv - request/control bundle between mult32x32_fsm and its peers
interface mult32x32_fsm_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [2:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  a_sel, b_sel, shift_sel, upd_prod, clr_prod, busy, done
  );

  modport slave (
    input  start, a, b,
    output a_sel, b_sel, shift_sel, upd_prod, clr_prod, busy, done
  );
endinterface

// File: rtl/mult32x32_fsm.sv
// rtl/mult32x32_fsm.sv - sequencing controller for mult32x32_arith (clear + 8 byte-by-halfword steps)
// Optional zero-operand step skipping: MULT32X32_FSM_SKIP_ZERO_EN
module mult32x32_fsm (
  input logic              clk,
  input logic              reset,
  mult32x32_fsm_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [7:0] active;
  logic       first_found, nxt_found;
  logic [2:0] first_k, nxt_k;

`ifdef MULT32X32_FSM_SKIP_ZERO_EN
  // A step contributes nothing when either its a byte or its b halfword is zero.
  always_comb begin
    active = '0;
    for (int i = 0; i < 8; i++) begin
      active[i] = (bus.a[8*(i%4) +: 8] != 8'd0) && (bus.b[16*(i/4) +: 16] != 16'd0);
    end
  end
`else
  assign active = 8'hFF;
`endif

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    first_found = 1'b0;
    first_k     = 3'd0;
    nxt_found   = 1'b0;
    nxt_k       = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) begin
        first_found = 1'b1;
        first_k     = 3'(i);
      end
      if (active[i] && (4'(i) > {1'b0, k_q})) begin
        nxt_found = 1'b1;
        nxt_k     = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          k_d     = 3'd0;
        end
      end
      S_CLEAR: begin
        if (first_found) begin
          state_d = S_MUL;
          k_d     = first_k;
        end else begin
          state_d = S_DONE;
          k_d     = 3'd0;
        end
      end
      S_MUL: begin
        if (nxt_found) begin
          k_d = nxt_k;
        end else begin
          state_d = S_DONE;
          k_d     = 3'd0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Moore outputs: selects are only non-zero while a MUL step is in flight.
  always_comb begin
    bus.a_sel     = 2'd0;
    bus.b_sel     = 1'b0;
    bus.shift_sel = 3'd0;
    bus.upd_prod  = 1'b0;
    bus.clr_prod  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        bus.clr_prod = 1'b1;
        bus.busy     = 1'b1;
      end
      S_MUL: begin
        bus.upd_prod  = 1'b1;
        bus.busy      = 1'b1;
        bus.a_sel     = k_q[1:0];
        bus.b_sel     = k_q[2];
        bus.shift_sel = {1'b0, k_q[1:0]} + {1'b0, k_q[2], 1'b0};
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult32x32_fsm.sv
// tb/tb_mult32x32_fsm.sv - self-checking bench for mult32x32_fsm with a behavioural arith peer
module tb_mult32x32_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult32x32_fsm_if bus();

  mult32x32_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural stand-in for mult32x32_arith, driven by the controller outputs.
  logic [63:0] prod;
  logic [7:0]  pa;
  logic [15:0] ph;
  logic [23:0] pp;
  assign pa = bus.a[8*bus.a_sel +: 8];
  assign ph = bus.b[16*bus.b_sel +: 16];
  assign pp = 24'(pa) * 24'(ph);

  always @(posedge clk) begin
    if (reset)             prod <= 64'd0;
    else if (bus.clr_prod) prod <= 64'd0;
    else if (bus.upd_prod) prod <= prod + ({40'd0, pp} << (8*bus.shift_sel));
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: which steps run and in what order, from the step rules alone.
  int exp_n;
  int exp_shifts[$];

  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b);
    exp_n = 0;
    exp_shifts.delete();
    for (int k = 0; k < 8; k++) begin
      int  byte_idx = k % 4;
      int  half_idx = k / 4;
      bit  act;
`ifdef MULT32X32_FSM_SKIP_ZERO_EN
      act = (((a >> (8*byte_idx)) & 32'hFF) != 0) && (((b >> (16*half_idx)) & 32'hFFFF) != 0);
`else
      act = 1'b1;
`endif
      if (act) begin
        exp_n++;
        exp_shifts.push_back(byte_idx + 2*half_idx);
      end
    end
  endfunction

  int          obs_lat, obs_done_cnt, obs_upd, obs_busy, obs_clr, obs_viol;
  logic [63:0] obs_prod;
  bit          obs_zero_after_rst;
  int          obs_shifts[$];

  function automatic logic [9:0] out_word();
    return {bus.a_sel, bus.b_sel, bus.shift_sel, bus.upd_prod, bus.clr_prod, bus.busy, bus.done};
  endfunction

  // Start one operation and watch a fixed 20-cycle window; j counts edges after the start edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at, input int reset_at);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    obs_lat = -1; obs_done_cnt = 0; obs_upd = 0; obs_busy = 0; obs_clr = 0; obs_viol = 0;
    obs_prod = '0; obs_zero_after_rst = 1'b0;
    obs_shifts.delete();
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      bus.start = (j == pulse_at);
      reset     = (j == reset_at);
      if (reset_at >= 0 && j == reset_at + 1) obs_zero_after_rst = (out_word() == 10'd0);
      if (bus.done) begin
        if (obs_lat < 0) begin
          obs_lat  = j;
          obs_prod = prod;
        end
        obs_done_cnt++;
      end
      if (bus.busy) obs_busy++;
      if (bus.clr_prod) obs_clr++;
      if (bus.upd_prod) begin
        obs_upd++;
        obs_shifts.push_back(int'(bus.shift_sel));
      end
      if (bus.upd_prod && bus.clr_prod) obs_viol++;
      if (!bus.busy && (bus.a_sel != 0 || bus.b_sel || bus.shift_sel != 0 || bus.upd_prod || bus.clr_prod))
        obs_viol++;
    end
    bus.start = 1'b0;
    reset     = 1'b0;
  endtask

  function automatic int shift_mismatches();
    int m = (obs_shifts.size() != exp_shifts.size()) ? 1 : 0;
    for (int i = 0; i < obs_shifts.size() && i < exp_shifts.size(); i++)
      if (obs_shifts[i] != exp_shifts[i]) m++;
    return m;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_prod;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{32'h000000FF, 32'hFFFF0000, 64'h000000FEFF010000, 9};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 9};
    vecs[2] = '{32'h00000003, 32'h00000005, 64'd15,               9};
    vecs[3] = '{32'h000000FF, 32'h0000FFFF, 64'h0000000000FEFF01, 9};
    vecs[4] = '{32'h00000000, 32'h12345678, 64'd0,                9};
`ifdef MULT32X32_FSM_SKIP_ZERO_EN
    vecs[0].exp_lat = 2;
    vecs[2].exp_lat = 2;
    vecs[3].exp_lat = 2;
    vecs[4].exp_lat = 1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(out_word()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", 64'(out_word()), 64'd0);

    for (int v = 0; v < 5; v++) begin
      ref_model(vecs[v].a, vecs[v].b);
      run_op(vecs[v].a, vecs[v].b, -1, -1);
      check($sformatf("vec%0d_latency", v), 64'(obs_lat), 64'(vecs[v].exp_lat));
      check($sformatf("vec%0d_product", v), obs_prod, vecs[v].exp_prod);
      check($sformatf("vec%0d_done_pulses", v), 64'(obs_done_cnt), 64'd1);
      check($sformatf("vec%0d_upd_cycles", v), 64'(obs_upd), 64'(exp_n));
      check($sformatf("vec%0d_busy_cycles", v), 64'(obs_busy), 64'(1 + exp_n));
      check($sformatf("vec%0d_clr_cycles", v), 64'(obs_clr), 64'd1);
      check($sformatf("vec%0d_shift_seq", v), 64'(shift_mismatches()), 64'd0);
      check($sformatf("vec%0d_output_rules", v), 64'(obs_viol), 64'd0);
    end

    // start re-pulsed during MUL step 3 must be ignored
    ref_model(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4, -1);
    check("repulse_done_pulses", 64'(obs_done_cnt), 64'd1);
    check("repulse_product", obs_prod, 64'hFFFFFFFE00000001);
    check("repulse_latency", 64'(obs_lat), 64'(1 + exp_n));
    check("repulse_busy_cycles", 64'(obs_busy), 64'(1 + exp_n));

    // reset during MUL step 4 aborts with no done, then a fresh operation works
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, -1, 5);
    check("abort_outputs_zero", 64'(obs_zero_after_rst), 64'd1);
    check("abort_done_pulses", 64'(obs_done_cnt), 64'd0);
    ref_model(32'd3, 32'd5);
    run_op(32'd3, 32'd5, -1, -1);
    check("after_abort_product", obs_prod, 64'd15);
    check("after_abort_latency", 64'(obs_lat), 64'(1 + exp_n));

    // randomized operands with sparse zero bytes/halves
    for (int r = 0; r < 16; r++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 2) == 0) ra[8*i +: 8] = 8'd0;
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 2) == 0) rb[16*i +: 16] = 16'd0;
      ref_model(ra, rb);
      run_op(ra, rb, -1, -1);
      check($sformatf("rand%0d_product a=%h b=%h", r, ra, rb), obs_prod, 64'(ra) * 64'(rb));
      check($sformatf("rand%0d_latency", r), 64'(obs_lat), 64'(1 + exp_n));
      check($sformatf("rand%0d_shift_seq", r), 64'(shift_mismatches()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
